// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator driven by a one-cycle pixel-enable tick.
// The horizontal and vertical counters advance once per tick. Every output
// is registered and decoded from the next-state counter values, so the
// coordinates, syncs, video_on and the strobes all change on the same edge.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 10
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_ACTIVE + H_FP;
   localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int VS_FIRST = V_ACTIVE + V_FP;
   localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

   // Active and inactive sync levels
   localparam logic SYNC_ACT   = (SYNC_POL != 0);
   localparam logic SYNC_INACT = ~SYNC_ACT;

   localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] X_ACT_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] Y_ACT_END = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(HS_FIRST);
   localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(HS_LAST);
   localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(VS_FIRST);
   localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(VS_LAST);

   logic             x_at_end;
   logic             y_at_end;
   logic [CNT_W-1:0] x_nxt;
   logic [CNT_W-1:0] y_nxt;
   logic             hs_act_nxt;
   logic             vs_act_nxt;
   logic             video_nxt;
   logic             line_nxt;
   logic             frame_nxt;

   assign x_at_end = (pixel_x == X_LAST);
   assign y_at_end = (pixel_y == Y_LAST);

   // Next counter position: advance on a tick, wrap x at end of line and y at end of frame
   always_comb begin
      x_nxt = pixel_x;
      y_nxt = pixel_y;
      if (pix_en) begin
         if (x_at_end) begin
            x_nxt = '0;
            if (y_at_end) begin
               y_nxt = '0;
            end else begin
               y_nxt = pixel_y + CNT_W'(1);
            end
         end else begin
            x_nxt = pixel_x + CNT_W'(1);
         end
      end
   end

   // Decode syncs, video window and strobes from the next position so they line up with it
   always_comb begin
      hs_act_nxt = (x_nxt >= HS_LO) && (x_nxt <= HS_HI);
      vs_act_nxt = (y_nxt >= VS_LO) && (y_nxt <= VS_HI);
      video_nxt  = (x_nxt < X_ACT_END) && (y_nxt < Y_ACT_END);
      line_nxt   = pix_en && x_at_end;
      frame_nxt  = pix_en && x_at_end && y_at_end;
   end

   // Output and counter registers; reset restarts the raster at (0,0) with no strobe
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         video_on    <= 1'b1;
         hsync       <= SYNC_INACT;
         vsync       <= SYNC_INACT;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pixel_x     <= x_nxt;
         pixel_y     <= y_nxt;
         video_on    <= video_nxt;
         hsync       <= hs_act_nxt ? SYNC_ACT : SYNC_INACT;
         vsync       <= vs_act_nxt ? SYNC_ACT : SYNC_INACT;
         line_start  <= line_nxt;
         frame_start <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-sized instance for line timing and a
// reduced-size instance so whole frames fit in a short run.
module tb_vga_timing_gen;

   // Reduced raster: 15 x 8, hsync x=10..12, vsync y=5..6, frame = 120 ticks
   localparam int SHA = 8, SHFP = 2, SHS = 3, SHBP = 2;
   localparam int SVA = 4, SVFP = 1, SVS = 2, SVBP = 1;
   localparam int SHT = SHA + SHFP + SHS + SHBP;
   localparam int SVT = SVA + SVFP + SVS + SVBP;
   localparam int DHT = 800, DVT = 525;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d, en_d, hs_d, vs_d, vid_d, ls_d, fs_d;
   logic [9:0] x_d, y_d;
   logic rst_s, en_s, hs_s, vs_s, vid_s, ls_s, fs_s;
   logic [9:0] x_s, y_s;

   vga_timing_gen dut_d (
      .clk_in(clk), .reset_n(rst_d), .pix_en(en_d),
      .hsync(hs_d), .vsync(vs_d), .video_on(vid_d),
      .pixel_x(x_d), .pixel_y(y_d),
      .line_start(ls_d), .frame_start(fs_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
      .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP),
      .SYNC_POL(0), .CNT_W(10)
   ) dut_s (
      .clk_in(clk), .reset_n(rst_s), .pix_en(en_s),
      .hsync(hs_s), .vsync(vs_s), .video_on(vid_s),
      .pixel_x(x_s), .pixel_y(y_s),
      .line_start(ls_s), .frame_start(fs_s)
   );

   logic [24:0] act_d, act_s;
   assign act_d = {x_d, y_d, vid_d, hs_d, vs_d, ls_d, fs_d};
   assign act_s = {x_s, y_s, vid_s, hs_s, vs_s, ls_s, fs_s};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: ticks since reset plus strobe flags
   int nd = 0, ns = 0;
   bit m_ls_d = 0, m_fs_d = 0, m_ls_s = 0, m_fs_s = 0;

   typedef struct {
      bit rst_n; bit en; int cycles;
      int x; int y; bit vid; bit hs; bit vs; bit ls; bit fs;
   } vec_t;
   vec_t tbl[16];

   function automatic logic [24:0] model_vec(int n, bit ls, bit fs,
         int ha, int hfp, int hs, int ht, int va, int vfp, int vs, int vt);
      int x, y;
      bit vid, hsy, vsy;
      x   = n % ht;
      y   = (n / ht) % vt;
      vid = (x < ha) && (y < va);
      hsy = !((x >= ha + hfp) && (x < ha + hfp + hs));
      vsy = !((y >= va + vfp) && (y < va + vfp + vs));
      return {10'(x), 10'(y), vid, hsy, vsy, ls, fs};
   endfunction

   task automatic check_vec(string name, logic [24:0] act, logic [24:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b",
                  name, act[24:15], act[14:5], act[4], act[3], act[2], act[1], act[0],
                  exp[24:15], exp[14:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: update the reference from the applied inputs, then compare both instances
   task automatic step();
      @(posedge clk);
      if (!rst_d) begin nd = 0; m_ls_d = 0; m_fs_d = 0; end
      else if (en_d) begin
         nd = (nd + 1) % (DHT * DVT);
         m_ls_d = (nd % DHT == 0); m_fs_d = (nd == 0);
      end else begin m_ls_d = 0; m_fs_d = 0; end
      if (!rst_s) begin ns = 0; m_ls_s = 0; m_fs_s = 0; end
      else if (en_s) begin
         ns = (ns + 1) % (SHT * SVT);
         m_ls_s = (ns % SHT == 0); m_fs_s = (ns == 0);
      end else begin m_ls_s = 0; m_fs_s = 0; end
      #1;
      check_vec("model_default", act_d,
                model_vec(nd, m_ls_d, m_fs_d, 640, 16, 96, DHT, 480, 10, 2, DVT));
      check_vec("model_small", act_s,
                model_vec(ns, m_ls_s, m_fs_s, SHA, SHFP, SHS, SHT, SVA, SVFP, SVS, SVT));
   endtask

   initial begin
      int lows, first_low, last_low, cnt_ls, cnt_fs, first_fs, vs_low;
      logic [24:0] snap;

      // Hand-derived vectors for the reduced raster, applied in order
      tbl[0]  = '{0, 1,  3,  0, 0, 1, 1, 1, 0, 0};
      tbl[1]  = '{1, 1,  1,  1, 0, 1, 1, 1, 0, 0};
      tbl[2]  = '{1, 1,  7,  8, 0, 0, 1, 1, 0, 0};
      tbl[3]  = '{1, 1,  2, 10, 0, 0, 0, 1, 0, 0};
      tbl[4]  = '{1, 1,  2, 12, 0, 0, 0, 1, 0, 0};
      tbl[5]  = '{1, 1,  1, 13, 0, 0, 1, 1, 0, 0};
      tbl[6]  = '{1, 1,  1, 14, 0, 0, 1, 1, 0, 0};
      tbl[7]  = '{1, 1,  1,  0, 1, 1, 1, 1, 1, 0};
      tbl[8]  = '{1, 0,  1,  0, 1, 1, 1, 1, 0, 0};
      tbl[9]  = '{1, 0,  5,  0, 1, 1, 1, 1, 0, 0};
      tbl[10] = '{1, 1, 60,  0, 5, 0, 1, 0, 1, 0};
      tbl[11] = '{1, 1, 30,  0, 7, 0, 1, 1, 1, 0};
      tbl[12] = '{1, 1, 14, 14, 7, 0, 1, 1, 0, 0};
      tbl[13] = '{1, 1,  1,  0, 0, 1, 1, 1, 1, 1};
      tbl[14] = '{1, 1,  1,  1, 0, 1, 1, 1, 0, 0};
      tbl[15] = '{0, 1,  1,  0, 0, 1, 1, 1, 0, 0};

      // Reset both instances for 3 cycles with pix_en high
      rst_d = 0; en_d = 1; rst_s = 0; en_s = 1;
      for (int i = 0; i < 3; i++) step();
      check_vec("reset_default", act_d, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      rst_d = 1; en_d = 0;

      // Table vectors on the reduced instance
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < tbl[r].cycles; c++) begin
            rst_s = tbl[r].rst_n; en_s = tbl[r].en;
            step();
         end
         check_vec($sformatf("table_row%0d", r), act_s,
                   {10'(tbl[r].x), 10'(tbl[r].y), tbl[r].vid, tbl[r].hs,
                    tbl[r].vs, tbl[r].ls, tbl[r].fs});
      end
      rst_s = 1; en_s = 0;

      // Default instance: one tick every 4th cycle across a full line
      lows = 0; first_low = -1; last_low = -1;
      for (int t = 1; t <= 800; t++) begin
         en_d = 0;
         for (int k = 0; k < 3; k++) step();
         en_d = 1;
         step();
         if (hs_d == 1'b0) begin
            lows++;
            if (first_low < 0) first_low = t;
            last_low = t;
         end
         if (t == 640) begin
            check_int("x_after_640", int'(x_d), 640);
            check_int("video_after_640", int'(vid_d), 0);
         end
         if (t == 752) check_int("hsync_at_752", int'(hs_d), 1);
      end
      en_d = 0;
      check_int("hsync_low_count", lows, 96);
      check_int("hsync_first_low", first_low, 656);
      check_int("hsync_last_low", last_low, 751);
      check_vec("line_wrap", act_d, {10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

      // Advance to x=300, then stall pix_en for 50 cycles
      en_d = 1;
      for (int i = 0; i < 300; i++) step();
      en_d = 0;
      snap = act_d;
      check_int("x_at_300", int'(x_d), 300);
      for (int i = 0; i < 50; i++) begin
         step();
         check_vec("stall_hold", act_d, snap);
      end

      // pix_en tied high: line_start every 800 cycles from x=300
      en_d = 1; cnt_ls = 0; first_fs = -1;
      for (int c = 1; c <= 1600; c++) begin
         step();
         if (ls_d) begin
            cnt_ls++;
            if (first_fs < 0) first_fs = c;
         end
      end
      en_d = 0;
      check_int("default_ls_count", cnt_ls, 2);
      check_int("default_ls_first", first_fs, 500);

      // Reduced instance: full frames with pix_en tied high
      rst_s = 0; step(); rst_s = 1; en_s = 1;
      cnt_ls = 0; cnt_fs = 0; first_fs = -1; vs_low = 0;
      for (int c = 1; c <= 245; c++) begin
         step();
         if (ls_s) cnt_ls++;
         if (fs_s) begin
            cnt_fs++;
            if (first_fs < 0) first_fs = c;
         end
         if (c <= 120 && vs_s == 1'b0) vs_low++;
      end
      check_int("small_ls_count", cnt_ls, 16);
      check_int("small_fs_count", cnt_fs, 2);
      check_int("small_fs_first", first_fs, 120);
      check_int("small_vsync_low", vs_low, 30);

      // Reset for one cycle mid-frame at (5,3)
      rst_s = 0; step(); rst_s = 1;
      for (int i = 0; i < 50; i++) step();
      check_vec("midframe_pos", act_s, {10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      rst_s = 0; step(); rst_s = 1;
      check_vec("midframe_reset", act_s, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      step();
      check_vec("after_reset_tick", act_s, {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

      // Randomized traffic on both instances against the reference
      for (int i = 0; i < 3000; i++) begin
         rst_s = ($urandom_range(0, 299) != 0);
         en_s  = ($urandom_range(0, 2) != 0);
         rst_d = ($urandom_range(0, 999) != 0);
         en_d  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
